pipe_ctrl_gen: RTL and testbench
================================

// Module: pipe_ctrl_gen
// PURPOSE
//  Parametrised successor to the core's stall-only CTRL: central pipeline controller for an N-stage in-order core.
//  Merges per-stage stall requests, runs a multi-cycle hold counter for long ops (mult/div), sequences
//  redirect/flush (exceptions, mispredict) and flags stall deadlock via a watchdog. Drives every stage's stall/flush bus.
// PARAMETERS
//  NSTAGE   5      pipeline stages after PC (IF..WB); stall bus is NSTAGE+1 wide, bit0 = PC reg
//  HOLD_W   6      width of hold length (max hold 2^HOLD_W-1 cycles)
//  WDOG     255    consecutive stalled cycles before stall_timeout sets (0 = disabled)
//  PC_W     32     redirect PC width
// PORTS
//  clk             in   1         core clock, rising edge
//  rst             in   1         async reset, active-low
//  stallreq        in   NSTAGE    bit i = stage i (0=IF) requests stall this cycle (combinational from stage)
//  hold_start      in   1         pulse: start multi-cycle hold
//  hold_stage      in   $clog2(NSTAGE) stage owning the hold (e.g. 2=EX)
//  hold_len        in   HOLD_W    hold cycles, sampled with hold_start
//  flush_req       in   1         redirect request (exception/eret/mispredict)
//  flush_stage     in   $clog2(NSTAGE) oldest stage to kill (it and all younger are flushed)
//  flush_pc        in   PC_W      redirect target
//  stall           out  NSTAGE+1  bit0 PC, bit i+1 stage i: hold pipeline register
//  flush           out  NSTAGE    bit i: load bubble into stage i register
//  redirect_valid  out  1         one-cycle pulse, PC loads redirect_pc
//  redirect_pc     out  PC_W      target, valid with redirect_valid
//  hold_busy       out  1         hold counter nonzero
//  stall_timeout   out  1         sticky watchdog flag, cleared only by reset
// BEHAVIOUR
//  Reset: stall=0, flush=0, redirect_valid=0, redirect_pc=0, hold_busy=0, stall_timeout=0, FSM=IDLE, counters=0.
//  Stall merge (comb): k = highest i with stallreq[i] | (hold_busy & hold_stage_q==i); stall[k+1:0]=1, rest 0;
//   flush[k+1]=1 (bubble into next stage) when k+1<NSTAGE. Same cycle as request (0 latency).
//  Hold counter: hold_start & hold_len!=0 loads cnt=hold_len, hold_stage_q=hold_stage; dec each cycle to 0;
//   hold_busy=(cnt!=0). hold_start with hold_len==0 ignored. hold_start while busy: reload (new op wins).
//  Flush FSM: IDLE -> FLUSH on flush_req (captures flush_stage, flush_pc). In FLUSH (exactly 1 cycle):
//   flush[s:0]=1 where s=captured stage, stall=0, redirect_valid=1, redirect_pc=captured pc; hold cnt cleared
//   if hold_stage_q<=s. FLUSH -> IDLE. Redirect latency: 1 cycle after flush_req.
//  Priority: FLUSH state overrides all stall merge. flush_req in FLUSH state: re-enter FLUSH next cycle with new
//   capture (back-to-back redirects allowed). flush_req with stallreq same cycle: stall applied this cycle, flush next.
//  Watchdog: wcnt increments while any stall bit set and FSM=IDLE, else clears; wcnt==WDOG sets stall_timeout;
//   wcnt saturates (no wrap).
//  Reset asserted mid-hold or mid-FLUSH: all state to reset values immediately (async), no redirect pulse.
//  Width rules: hold counter unsigned HOLD_W; flush_stage >= NSTAGE treated as NSTAGE-1.
// STRUCTURE
//  Shared package/defines: StallBus = NSTAGE+1, stage index constants (IF=0,ID=1,EX=2,MEM=3,WB=4), FSM
//  state encoding {IDLE,FLUSH}. One natural sub-module: pipe_hold_cnt (load/decrement counter + owner stage reg).
//  Stall merge is a priority encoder in the top; watchdog inline.
// TESTING
//  1 stallreq=5'b00010 (ID) one cycle -> stall=6'b000111, flush=5'b00100, clear next cycle.
//  2 hold_start, hold_stage=2, hold_len=4 -> stall=6'b001111 for exactly 4 cycles, hold_busy high 4 cycles.
//  3 flush_req, flush_stage=3, flush_pc=0xBFC00380 -> next cycle flush=5'b01111, stall=0, redirect_valid=1 one cycle,
//    redirect_pc=0xBFC00380; active hold on stage 2 cleared.
//  4 flush_req on two consecutive cycles (pc 0x100 then 0x200) -> two redirect pulses, 0x100 then 0x200.
//  5 WDOG=8, stallreq[2] held 20 cycles -> stall_timeout sets on 9th stalled cycle, stays set after release.
//  6 assert rst low during hold (cnt=3) and in FLUSH -> all outputs 0 at once, no redirect after release.

Source files
------------

// File: rtl/pipe_ctrl_gen_pkg.sv
// Shared definitions for the pipeline controller: stage indices, FSM encoding, bus sizing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_gen_pkg;

    // Stage indices for the default 5-stage in-order core.
    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;
    localparam int STAGE_WB  = 4;

    localparam int NSTAGE_DEF = 5;

    // Redirect sequencer states. FLUSH lasts exactly one cycle unless re-entered.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_t;

    // Stall bus carries one extra bit for the PC register (bit 0).
    function automatic int stall_bus_w(input int nstage);
        return nstage + 1;
    endfunction

endpackage

// File: rtl/pipe_hold_cnt.sv
// Multi-cycle hold counter: loads a length and owner stage, counts down to zero.
// Latency: busy rises the cycle after a nonzero load; drops after hold_len cycles.
// Backpressure: none; a new load always wins over an in-flight hold or a clear.
//
// Ports:
//   clk, rst          clock / async active-low reset
//   load, load_stage, load_len   start request (ignored when load_len == 0)
//   clr               kill the current hold (redirect squashed its owner)
//   busy, owner       counter nonzero / stage that owns the hold
module pipe_hold_cnt
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int HOLD_W = 6,
    parameter int SIDX_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [SIDX_W-1:0] load_stage,
    input  logic [HOLD_W-1:0] load_len,
    input  logic              clr,
    output logic              busy,
    output logic [SIDX_W-1:0] owner
);

    logic [HOLD_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            owner <= SIDX_W'(STAGE_IF);
        end else if (load && (load_len != '0)) begin
            cnt   <= load_len;
            owner <= load_stage;
        end else if (clr) begin
            cnt   <= '0;
        end else if (cnt != '0) begin
            cnt   <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Central pipeline controller: stall merge, multi-cycle hold, redirect/flush sequencing, stall watchdog.
// Latency: stall/flush merge is combinational (0 cycles); redirect pulse 1 cycle after flush_req.
// Backpressure: a redirect overrides all stalls for its FLUSH cycle; stalls otherwise freeze stages 0..k+1.
//
// Ports:
//   clk, rst                      clock / async active-low reset
//   stallreq                      per-stage stall requests (bit 0 = IF)
//   hold_start/stage/len          start a multi-cycle hold owned by a stage
//   flush_req/stage/pc            redirect request: kill stage and younger, fetch from pc
//   stall                         bit 0 PC reg, bit i+1 stage i register hold
//   flush                         bit i loads a bubble into stage i register
//   redirect_valid/redirect_pc    one-cycle PC redirect
//   hold_busy                     hold counter running
//   stall_timeout                 sticky watchdog flag
module pipe_ctrl_gen
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int HOLD_W = 6,
    parameter int WDOG   = 255,
    parameter int PC_W   = 32,
    localparam int SIDX_W = (NSTAGE > 1) ? $clog2(NSTAGE) : 1,
    localparam int SBUS_W = stall_bus_w(NSTAGE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              hold_start,
    input  logic [SIDX_W-1:0] hold_stage,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic              flush_req,
    input  logic [SIDX_W-1:0] flush_stage,
    input  logic [PC_W-1:0]   flush_pc,
    output logic [SBUS_W-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              hold_busy,
    output logic              stall_timeout
);

    // Out-of-range stage indices collapse onto the last stage.
    function automatic logic [SIDX_W-1:0] clamp_stage(input logic [SIDX_W-1:0] s);
        if (int'(s) >= NSTAGE) begin
            return SIDX_W'(NSTAGE - 1);
        end
        return s;
    endfunction

    flush_state_t      state_q, state_d;
    logic [SIDX_W-1:0] cap_stage_q;
    logic [PC_W-1:0]   cap_pc_q;
    logic [SIDX_W-1:0] hold_owner;
    logic              hold_clr;

    // ------------------------------------------------------------------
    // Hold counter
    // ------------------------------------------------------------------
    // Only a hold whose owner sits in the squashed range dies with a redirect;
    // an older stage's long op keeps running.
    assign hold_clr = (state_q == ST_FLUSH) && (hold_owner <= cap_stage_q);

    pipe_hold_cnt #(
        .HOLD_W (HOLD_W),
        .SIDX_W (SIDX_W)
    ) u_hold_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_start),
        .load_stage (clamp_stage(hold_stage)),
        .load_len   (hold_len),
        .clr        (hold_clr),
        .busy       (hold_busy),
        .owner      (hold_owner)
    );

    // ------------------------------------------------------------------
    // Stall merge: priority encode the oldest-in-pipe (highest index)
    // stalling stage k; everything upstream of it, plus k itself and the PC,
    // holds; the stage downstream of k receives a bubble.
    // ------------------------------------------------------------------
    logic [NSTAGE-1:0] req_eff;
    logic              any_stall;
    int                top_k;
    logic [SBUS_W-1:0] merge_stall;
    logic [NSTAGE-1:0] merge_flush;

    always_comb begin
        req_eff     = stallreq;
        any_stall   = 1'b0;
        top_k       = 0;
        merge_stall = '0;
        merge_flush = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (hold_busy && (hold_owner == SIDX_W'(i))) begin
                req_eff[i] = 1'b1;
            end
        end
        for (int i = 0; i < NSTAGE; i++) begin
            if (req_eff[i]) begin
                any_stall = 1'b1;
                top_k     = i;
            end
        end
        if (any_stall) begin
            for (int i = 0; i < SBUS_W; i++) begin
                if (i <= top_k + 1) begin
                    merge_stall[i] = 1'b1;
                end
            end
            for (int i = 0; i < NSTAGE; i++) begin
                if (i == top_k + 1) begin
                    merge_flush[i] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Redirect FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cap_stage_q <= '0;
            cap_pc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (flush_req) begin
                cap_stage_q <= clamp_stage(flush_stage);
                cap_pc_q    <= flush_pc;
            end
        end
    end

    // A new request in FLUSH simply re-enters FLUSH with the fresh capture,
    // giving back-to-back redirect pulses.
    always_comb begin
        state_d        = ST_IDLE;
        stall          = merge_stall;
        flush          = merge_flush;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (flush_req) begin
            state_d = ST_FLUSH;
        end
        if (state_q == ST_FLUSH) begin
            stall          = '0;
            flush          = '0;
            redirect_valid = 1'b1;
            redirect_pc    = cap_pc_q;
            for (int i = 0; i < NSTAGE; i++) begin
                if (SIDX_W'(i) <= cap_stage_q) begin
                    flush[i] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall watchdog: count consecutive stalled IDLE cycles, saturating.
    // The flag is visible in the same cycle the count reaches WDOG and
    // stays set until reset.
    // ------------------------------------------------------------------
    generate
        if (WDOG > 0) begin : g_wdog
            localparam int WCNT_W = $clog2(WDOG + 1);
            logic [WCNT_W-1:0] wcnt;
            logic              timeout_q;
            logic              stalled;
            logic              wdog_hit;

            assign stalled  = (|stall) && (state_q == ST_IDLE);
            assign wdog_hit = (wcnt == WCNT_W'(WDOG));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wcnt      <= '0;
                    timeout_q <= 1'b0;
                end else begin
                    if (!stalled) begin
                        wcnt <= '0;
                    end else if (!wdog_hit) begin
                        wcnt <= wcnt + 1'b1;
                    end
                    if (wdog_hit) begin
                        timeout_q <= 1'b1;
                    end
                end
            end

            assign stall_timeout = timeout_q | wdog_hit;
        end else begin : g_no_wdog
            assign stall_timeout = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
module tb_pipe_ctrl_gen;

    localparam int NSTAGE = 5;
    localparam int HOLD_W = 6;
    localparam int WDOG   = 8;
    localparam int PC_W   = 32;

    logic              clk;
    logic              rst;
    logic [NSTAGE-1:0] stallreq;
    logic              hold_start;
    logic [2:0]        hold_stage;
    logic [HOLD_W-1:0] hold_len;
    logic              flush_req;
    logic [2:0]        flush_stage;
    logic [PC_W-1:0]   flush_pc;
    logic [NSTAGE:0]   stall;
    logic [NSTAGE-1:0] flush;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              hold_busy;
    logic              stall_timeout;

    int total_cnt;
    int pass_cnt;

    pipe_ctrl_gen #(
        .NSTAGE (NSTAGE),
        .HOLD_W (HOLD_W),
        .WDOG   (WDOG),
        .PC_W   (PC_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq       (stallreq),
        .hold_start     (hold_start),
        .hold_stage     (hold_stage),
        .hold_len       (hold_len),
        .flush_req      (flush_req),
        .flush_stage    (flush_stage),
        .flush_pc       (flush_pc),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hold_busy      (hold_busy),
        .stall_timeout  (stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1);
    end

    // Ends at posedge + 1 with reset released and inputs idle.
    task automatic apply_reset();
        rst         = 1'b0;
        stallreq    = '0;
        hold_start  = 1'b0;
        hold_stage  = '0;
        hold_len    = '0;
        flush_req   = 1'b0;
        flush_stage = '0;
        flush_pc    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        stallreq = '0; hold_start = 0; hold_stage = '0; hold_len = '0;
        flush_req = 0; flush_stage = '0; flush_pc = '0;
        @(negedge clk);
        total_cnt++;
        if ({stall, flush, redirect_valid, redirect_pc, hold_busy, stall_timeout} !== '0)
            $display("FAIL reset_outputs stall=%b flush=%b rv=%b pc=%h busy=%b to=%b exp all 0",
                     stall, flush, redirect_valid, redirect_pc, hold_busy, stall_timeout);
        else pass_cnt++;
        apply_reset();
        @(negedge clk);
        total_cnt++;
        if ({stall, flush, redirect_valid, hold_busy, stall_timeout} !== '0)
            $display("FAIL post_reset_idle stall=%b flush=%b rv=%b busy=%b to=%b exp all 0",
                     stall, flush, redirect_valid, hold_busy, stall_timeout);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_stall_merge();
        apply_reset();
        stallreq = 5'b00010;
        @(negedge clk);
        total_cnt++;
        if (stall !== 6'b000111) $display("FAIL stall_id stall=%b exp 000111", stall);
        else pass_cnt++;
        total_cnt++;
        if (flush !== 5'b00100) $display("FAIL stall_id_flush flush=%b exp 00100", flush);
        else pass_cnt++;
        next_cycle();
        stallreq = 5'b00000;
        @(negedge clk);
        total_cnt++;
        if (stall !== 6'b000000 || flush !== 5'b00000)
            $display("FAIL stall_clear stall=%b flush=%b exp 000000/00000", stall, flush);
        else pass_cnt++;
        next_cycle();
        // Multiple requesters: the highest stage wins; WB has no downstream bubble.
        stallreq = 5'b10001;
        @(negedge clk);
        total_cnt++;
        if (stall !== 6'b111111 || flush !== 5'b00000)
            $display("FAIL stall_wb stall=%b flush=%b exp 111111/00000", stall, flush);
        else pass_cnt++;
        next_cycle();
        stallreq = 5'b00101;
        @(negedge clk);
        total_cnt++;
        if (stall !== 6'b001111 || flush !== 5'b01000)
            $display("FAIL stall_ex_if stall=%b flush=%b exp 001111/01000", stall, flush);
        else pass_cnt++;
        next_cycle();
        stallreq = '0;
    endtask

    task automatic test_hold();
        apply_reset();
        hold_start = 1; hold_stage = 3'd2; hold_len = 6'd4;
        @(negedge clk);
        total_cnt++;
        if (stall !== 6'b000000 || hold_busy !== 1'b0)
            $display("FAIL hold_load_cycle stall=%b busy=%b exp 000000/0", stall, hold_busy);
        else pass_cnt++;
        next_cycle();
        hold_start = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            total_cnt++;
            if (stall !== 6'b001111 || flush !== 5'b01000 || hold_busy !== 1'b1)
                $display("FAIL hold_cycle%0d stall=%b flush=%b busy=%b exp 001111/01000/1",
                         c, stall, flush, hold_busy);
            else pass_cnt++;
            next_cycle();
        end
        @(negedge clk);
        total_cnt++;
        if (stall !== 6'b000000 || hold_busy !== 1'b0)
            $display("FAIL hold_end stall=%b busy=%b exp 000000/0", stall, hold_busy);
        else pass_cnt++;
        next_cycle();
        // Zero-length start is ignored.
        hold_start = 1; hold_stage = 3'd3; hold_len = 6'd0;
        next_cycle();
        hold_start = 0;
        @(negedge clk);
        total_cnt++;
        if (hold_busy !== 1'b0 || stall !== 6'b000000)
            $display("FAIL hold_len0 busy=%b stall=%b exp 0/000000", hold_busy, stall);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_flush();
        apply_reset();
        hold_start = 1; hold_stage = 3'd2; hold_len = 6'd10;
        next_cycle();
        hold_start = 0;
        flush_req = 1; flush_stage = 3'd3; flush_pc = 32'hBFC0_0380;
        @(negedge clk);
        total_cnt++;
        if (stall !== 6'b001111 || redirect_valid !== 1'b0)
            $display("FAIL flush_req_cycle stall=%b rv=%b exp 001111/0", stall, redirect_valid);
        else pass_cnt++;
        next_cycle();
        flush_req = 0;
        @(negedge clk);
        total_cnt++;
        if (flush !== 5'b01111 || stall !== 6'b000000)
            $display("FAIL flush_bus flush=%b stall=%b exp 01111/000000", flush, stall);
        else pass_cnt++;
        total_cnt++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0380)
            $display("FAIL flush_redirect rv=%b pc=%h exp 1/bfc00380", redirect_valid, redirect_pc);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (redirect_valid !== 1'b0 || hold_busy !== 1'b0 || stall !== 6'b000000 || flush !== 5'b00000)
            $display("FAIL flush_after rv=%b busy=%b stall=%b flush=%b exp 0/0/000000/00000",
                     redirect_valid, hold_busy, stall, flush);
        else pass_cnt++;
        next_cycle();
        // Hold owned by MEM survives a flush of IF..ID, and out-of-range stage clamps to WB.
        hold_start = 1; hold_stage = 3'd3; hold_len = 6'd10;
        next_cycle();
        hold_start = 0;
        flush_req = 1; flush_stage = 3'd1; flush_pc = 32'h0000_0040;
        next_cycle();
        flush_req = 0;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (hold_busy !== 1'b1 || stall !== 6'b011111)
            $display("FAIL flush_older_hold busy=%b stall=%b exp 1/011111", hold_busy, stall);
        else pass_cnt++;
        next_cycle();
        flush_req = 1; flush_stage = 3'd7; flush_pc = 32'h0000_0080;
        next_cycle();
        flush_req = 0;
        @(negedge clk);
        total_cnt++;
        if (flush !== 5'b11111 || redirect_pc !== 32'h0000_0080)
            $display("FAIL flush_clamp flush=%b pc=%h exp 11111/00000080", flush, redirect_pc);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        flush_req = 1; flush_stage = 3'd1; flush_pc = 32'h0000_0100;
        next_cycle();
        flush_req = 1; flush_stage = 3'd4; flush_pc = 32'h0000_0200;
        @(negedge clk);
        total_cnt++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0100 || flush !== 5'b00011)
            $display("FAIL b2b_first rv=%b pc=%h flush=%b exp 1/00000100/00011",
                     redirect_valid, redirect_pc, flush);
        else pass_cnt++;
        next_cycle();
        flush_req = 0;
        @(negedge clk);
        total_cnt++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0200 || flush !== 5'b11111)
            $display("FAIL b2b_second rv=%b pc=%h flush=%b exp 1/00000200/11111",
                     redirect_valid, redirect_pc, flush);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (redirect_valid !== 1'b0)
            $display("FAIL b2b_end rv=%b exp 0", redirect_valid);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_watchdog();
        apply_reset();
        stallreq = 5'b00100;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            total_cnt++;
            if (stall_timeout !== (n >= 9))
                $display("FAIL wdog_cycle%0d timeout=%b exp %b", n, stall_timeout, (n >= 9));
            else pass_cnt++;
            next_cycle();
        end
        stallreq = '0;
        repeat (3) next_cycle();
        @(negedge clk);
        total_cnt++;
        if (stall_timeout !== 1'b1 || stall !== 6'b000000)
            $display("FAIL wdog_sticky timeout=%b stall=%b exp 1/000000", stall_timeout, stall);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        hold_start = 1; hold_stage = 3'd2; hold_len = 6'd5;
        next_cycle();
        hold_start = 0;
        next_cycle();
        next_cycle();
        total_cnt++;
        if (hold_busy !== 1'b1 || stall !== 6'b001111)
            $display("FAIL rst_mid_hold_pre busy=%b stall=%b exp 1/001111", hold_busy, stall);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({stall, flush, redirect_valid, redirect_pc, hold_busy, stall_timeout} !== '0)
            $display("FAIL rst_mid_hold stall=%b flush=%b rv=%b busy=%b exp all 0",
                     stall, flush, redirect_valid, hold_busy);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (hold_busy !== 1'b0 || stall !== 6'b000000)
            $display("FAIL rst_hold_after busy=%b stall=%b exp 0/000000", hold_busy, stall);
        else pass_cnt++;
        next_cycle();
        flush_req = 1; flush_stage = 3'd2; flush_pc = 32'h0000_0300;
        next_cycle();
        flush_req = 0;
        total_cnt++;
        if (redirect_valid !== 1'b1)
            $display("FAIL rst_mid_flush_pre rv=%b exp 1", redirect_valid);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (redirect_valid !== 1'b0 || flush !== 5'b00000 || redirect_pc !== '0 || stall !== 6'b000000)
            $display("FAIL rst_mid_flush rv=%b flush=%b pc=%h stall=%b exp 0/00000/0/000000",
                     redirect_valid, flush, redirect_pc, stall);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            total_cnt++;
            if (redirect_valid !== 1'b0)
                $display("FAIL rst_no_redirect%0d rv=%b exp 0", c, redirect_valid);
            else pass_cnt++;
        end
        next_cycle();
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        test_reset();
        test_stall_merge();
        test_hold();
        test_flush();
        test_back_to_back();
        test_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
